load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Request-side front end for the 256x32 data memory unit; sits directly upstream of it and drives its en/wen/addr/data_in while consuming its registered data_out.
- Accepts one load or store at a time from the processor over a valid/ready request channel and returns one response per request over a valid/ready response channel.
- Implements byte-enabled (sub-word) stores as read-modify-write, since the memory only writes whole words.

Parameters:
- ADDR_W, 8, word-address width; must match the memory address bus.
- DATA_W, 32, data word width; must be a multiple of 8. Byte lanes = DATA_W/8.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  store data.
- req_be  in  DATA_W/8  store byte enables; bit i selects bits [8i+7:8i]; ignored for loads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DATA_W  load: word read; store: word as written (merged).
- mem_en  out  1  to memory enable.
- mem_wen  out  1  to memory write enable.
- mem_addr  out  ADDR_W  to memory address.
- mem_wdata  out  DATA_W  to memory data_in.
- mem_rdata  in  DATA_W  from memory data_out (valid the cycle after a read cycle).

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- States: IDLE, RD, RD_CAP, WR, RESP. Reset -> IDLE; latched addr/wdata/be/we and rsp_rdata cleared to 0.
- Reset outputs: req_ready=1 (IDLE), rsp_valid=0, rsp_rdata=0, mem_en=0, mem_wen=0, mem_addr=0, mem_wdata=0.
- mem_* are decoded from state and gated by rst_n: a reset cycle never issues a memory access, even when the state is RD or WR.
- mem_addr/mem_wdata = latched values while in RD/WR, else 0.
- IDLE: req_ready=1. On req_valid&&req_ready, latch the request. Next state:
  - load -> RD.
  - store with be all-ones -> WR; merged word = wdata.
  - store with be partial (not 0, not all-ones) -> RD.
  - store with be=0 -> RESP; rsp_rdata=0; no memory access.
- RD: mem_en=1, mem_wen=0 for exactly one cycle -> RD_CAP.
- RD_CAP: mem_en=0. Sample mem_rdata this cycle.
  - Load: rsp_rdata <= mem_rdata -> RESP.
  - Store: merged = per byte (be[i] ? wdata byte : mem_rdata byte) -> WR.
- WR: mem_en=1, mem_wen=1, mem_wdata=merged for one cycle. rsp_rdata <= merged -> RESP.
- RESP: rsp_valid=1; rsp_rdata held stable until the handshake. On rsp_ready -> IDLE. No request is accepted in the same cycle as the response handshake.
- req_ready=0 in every state except IDLE; requests presented while busy are not consumed.
- Latency from accept edge to rsp_valid:
  - full store: 2 cycles.
  - load: 3 cycles.
  - partial store: 4 cycles.
  - be=0 store: 1 cycle.
- Address wrap: none. Address 255 is an ordinary word, and there is no carry.
- Reset mid-operation: any in-flight request is dropped, no response is issued, and a pending RMW write is not performed.

Test Plan:
- After reset with rst_n=0 for 2 cycles: req_ready=1, rsp_valid=0, all mem_* = 0.
- Store addr=0x10, wdata=0xDEADBEEF, be=4'hF: WR cycle shows mem_en=1/mem_wen=1/mem_addr=0x10. rsp_valid 2 cycles after accept with rsp_rdata=0xDEADBEEF. Load 0x10 then returns 0xDEADBEEF 3 cycles after accept.
- Partial store to 0x10 with wdata=0x000000AA, be=4'b0001 -> RD then WR. rsp_rdata=0xDEADBEAA. A following load returns 0xDEADBEAA.
- Back-pressure: hold rsp_ready=0 for 5 cycles on a load. rsp_valid and rsp_rdata stay stable, req_ready=0, and a second req_valid is not accepted until the cycle after the rsp handshake.
- Store with be=0 to 0xFF: no mem_en pulse; rsp_valid 1 cycle after accept with rsp_rdata=0. A following load of 0xFF returns 0.
- Assert rst_n=0 in the WR cycle of a partial store to 0x20: mem_en=0 that cycle, rsp_valid never rises, and a following load of 0x20 returns the previous contents.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request/response channel between the processor and the load/store unit.
// The processor drives the master side; the load/store unit is the slave.
interface load_store_unit_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Front end for the 256x32 word memory: one load/store in flight at a time,
// with sub-word stores done as read-modify-write because the memory only writes whole words.
module load_store_unit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    load_store_unit_if.slave  bus,
    output logic              mem_en,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [2:0] {IDLE, RD, RD_CAP, WR, RESP} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic              we_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] merged;
    logic              access;

    always_comb begin
        merged = mem_rdata;
        for (int i = 0; i < BE_W; i++) begin
            if (be_q[i]) begin
                merged[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    // wdata_q is reused to hold the merged word once the read half of an RMW completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        be_q    <= bus.req_be;
                        we_q    <= bus.req_we;
                        if (!bus.req_we) begin
                            state <= RD;
                        end else if (&bus.req_be) begin
                            state <= WR;
                        end else if (|bus.req_be) begin
                            state <= RD;
                        end else begin
                            rdata_q <= '0;
                            state   <= RESP;
                        end
                    end
                end
                RD: begin
                    state <= RD_CAP;
                end
                RD_CAP: begin
                    if (we_q) begin
                        wdata_q <= merged;
                        state   <= WR;
                    end else begin
                        rdata_q <= mem_rdata;
                        state   <= RESP;
                    end
                end
                WR: begin
                    rdata_q <= wdata_q;
                    state   <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory strobes are gated by reset so a reset cycle can never write a half-done RMW.
    assign access    = rst_n && (state == RD || state == WR);
    assign mem_en    = access;
    assign mem_wen   = rst_n && (state == WR);
    assign mem_addr  = access ? addr_q  : '0;
    assign mem_wdata = access ? wdata_q : '0;

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural 256x32 memory
// whose data_out is registered one cycle after a read.
module tb_load_store_unit;
    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_acc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_en;
    logic        mem_wen;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    logic [31:0] mem_array [256] = '{default: 32'h0};
    int          acc_total = 0;
    logic [7:0]  last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;

    int checks = 0;
    int errors = 0;

    load_store_unit_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    load_store_unit #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .mem_en    (mem_en),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            acc_total = acc_total + 1;
            if (mem_wen) begin
                mem_array[mem_addr] <= mem_wdata;
                last_wr_addr        <= mem_addr;
                last_wr_data        <= mem_wdata;
            end else begin
                mem_rdata <= mem_array[mem_addr];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at the negedge right after the accept edge; lat counts edges from accept.
    task automatic waitResponse(output int lat);
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic completeResponse();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic driveRequest(input logic we, input logic [7:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
    endtask

    task automatic applyStimulus(input vec_t v, output int lat, output logic [31:0] rdata,
                                 output int acc);
        int acc0;
        @(negedge clk);
        acc0 = acc_total;
        driveRequest(v.we, v.addr, v.wdata, v.be);
        checkOutput("req_ready before accept", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        waitResponse(lat);
        rdata = bus.rsp_rdata;
        completeResponse();
        acc = acc_total - acc0;
    endtask

    vec_t        vectors [14];
    int          lat;
    int          acc;
    logic [31:0] rdata;
    vec_t        tail_vec;

    initial begin
        //                we    addr   wdata          be       exp_rdata      lat acc
        vectors[0]  = '{1'b1, 8'h10, 32'hDEADBEEF, 4'hF,    32'hDEADBEEF, 2, 1};
        vectors[1]  = '{1'b0, 8'h10, 32'h0,        4'h0,    32'hDEADBEEF, 3, 1};
        vectors[2]  = '{1'b1, 8'h10, 32'h000000AA, 4'b0001, 32'hDEADBEAA, 4, 2};
        vectors[3]  = '{1'b0, 8'h10, 32'h0,        4'h0,    32'hDEADBEAA, 3, 1};
        vectors[4]  = '{1'b1, 8'hFF, 32'h12345678, 4'h0,    32'h00000000, 1, 0};
        vectors[5]  = '{1'b0, 8'hFF, 32'h0,        4'h0,    32'h00000000, 3, 1};
        vectors[6]  = '{1'b1, 8'hFF, 32'hCAFEF00D, 4'hF,    32'hCAFEF00D, 2, 1};
        vectors[7]  = '{1'b1, 8'hFF, 32'h11223344, 4'b1010, 32'h11FE330D, 4, 2};
        vectors[8]  = '{1'b0, 8'hFF, 32'h0,        4'h0,    32'h11FE330D, 3, 1};
        vectors[9]  = '{1'b1, 8'h20, 32'hA5A5A5A5, 4'hF,    32'hA5A5A5A5, 2, 1};
        vectors[10] = '{1'b0, 8'h00, 32'h0,        4'h0,    32'h00000000, 3, 1};
        vectors[11] = '{1'b1, 8'h20, 32'h0000BB00, 4'b0010, 32'hA5A5BBA5, 4, 2};
        vectors[12] = '{1'b1, 8'h21, 32'h00FF0000, 4'b0100, 32'h00FF0000, 4, 2};
        vectors[13] = '{1'b0, 8'h21, 32'h0,        4'h0,    32'h00FF0000, 3, 1};

        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
        bus.rsp_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("reset req_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("reset rsp_rdata", bus.rsp_rdata, 32'd0);
        checkOutput("reset mem_en", 32'(mem_en), 32'd0);
        checkOutput("reset mem_wen", 32'(mem_wen), 32'd0);
        checkOutput("reset mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("reset mem_wdata", mem_wdata, 32'd0);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vectors[i], lat, rdata, acc);
            checkOutput($sformatf("v%0d latency", i), 32'(lat), 32'(vectors[i].exp_lat));
            checkOutput($sformatf("v%0d rsp_rdata", i), rdata, vectors[i].exp_rdata);
            checkOutput($sformatf("v%0d mem accesses", i), 32'(acc), 32'(vectors[i].exp_acc));
            if (vectors[i].we && vectors[i].exp_acc > 0) begin
                checkOutput($sformatf("v%0d write addr", i), 32'(last_wr_addr), 32'(vectors[i].addr));
                checkOutput($sformatf("v%0d write data", i), last_wr_data, vectors[i].exp_rdata);
            end
        end

        // Back-pressure: response held for 5 cycles while a store waits at the request port.
        @(negedge clk);
        driveRequest(1'b0, 8'h10, 32'h0, 4'h0);
        @(posedge clk);
        @(negedge clk);
        driveRequest(1'b1, 8'h30, 32'h77777777, 4'hF);
        waitResponse(lat);
        checkOutput("bp load latency", 32'(lat), 32'd3);
        checkOutput("bp load rsp_rdata", bus.rsp_rdata, 32'hDEADBEAA);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput($sformatf("bp hold%0d rsp_valid", i), 32'(bus.rsp_valid), 32'd1);
            checkOutput($sformatf("bp hold%0d rsp_rdata", i), bus.rsp_rdata, 32'hDEADBEAA);
            checkOutput($sformatf("bp hold%0d req_ready", i), 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        checkOutput("bp handshake req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        checkOutput("bp after handshake req_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("bp after handshake rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        waitResponse(lat);
        checkOutput("bp store latency", 32'(lat), 32'd2);
        checkOutput("bp store rsp_rdata", bus.rsp_rdata, 32'h77777777);
        completeResponse();
        tail_vec = '{1'b0, 8'h30, 32'h0, 4'h0, 32'h77777777, 3, 1};
        applyStimulus(tail_vec, lat, rdata, acc);
        checkOutput("bp readback 0x30", rdata, 32'h77777777);

        // Reset lands in the WR cycle of a partial store; the write must be lost.
        @(negedge clk);
        driveRequest(1'b1, 8'h20, 32'h000000CC, 4'b0001);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("rmw WR mem_wen", 32'(mem_wen), 32'd1);
        checkOutput("rmw WR mem_addr", 32'(mem_addr), 32'h20);
        rst_n = 1'b0;
        #1;
        checkOutput("rmw reset mem_en", 32'(mem_en), 32'd0);
        checkOutput("rmw reset mem_wen", 32'(mem_wen), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("rmw post-reset req_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("rmw post-reset rsp_rdata", bus.rsp_rdata, 32'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("rmw no response %0d", i), 32'(bus.rsp_valid), 32'd0);
            @(negedge clk);
        end
        tail_vec = '{1'b0, 8'h20, 32'h0, 4'h0, 32'hA5A5BBA5, 3, 1};
        applyStimulus(tail_vec, lat, rdata, acc);
        checkOutput("rmw readback latency", 32'(lat), 32'd3);
        checkOutput("rmw readback 0x20", rdata, 32'hA5A5BBA5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
